// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for alu_secuencial_param.
// OP_DIV is only decoded as a real operation when ALU_DIV_EN is defined.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_EQ  = 4'b0101;
  localparam logic [3:0] OP_GT  = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  function automatic logic is_div_op(input logic [3:0] op);
    return op == OP_DIV;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier and, with ALU_DIV_EN, a restoring divider.
// Both share one {acc_hi, acc_lo} accumulator; lo/hi expose the value being written this edge.
module alu_seq_muldiv #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH:0]   mul_sum;

`ifdef ALU_DIV_EN
  logic             op_q, op_d;
  logic [WIDTH:0]   div_part;
  logic [WIDTH-1:0] div_trial;
  logic             div_ok;
`else
  logic             unused_op;
  assign unused_op = op;
`endif

  // opnd holds the multiplicand (MUL) or the divisor (DIV); acc_lo starts as multiplier or dividend
  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
`ifdef ALU_DIV_EN
    op_d      = op_q;
    div_part  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ok    = div_part >= {1'b0, opnd_q};
    div_trial = div_part[WIDTH-1:0] - opnd_q;
`endif
    if (start) begin
      cnt_d    = CNT_W'(WIDTH);
      acc_hi_d = '0;
`ifdef ALU_DIV_EN
      op_d     = op;
      acc_lo_d = op ? a : b;
      opnd_d   = op ? b : a;
`else
      acc_lo_d = b;
      opnd_d   = a;
`endif
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
`ifdef ALU_DIV_EN
      if (op_q) begin
        if (div_ok) begin
          acc_hi_d = div_trial;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = div_part[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
`else
      acc_hi_d = mul_sum[WIDTH:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
`ifdef ALU_DIV_EN
      op_q     <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
`ifdef ALU_DIV_EN
      op_q     <= op_d;
`endif
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign lo   = acc_lo_d;
  assign hi   = acc_hi_d;

endmodule

// File: rtl/alu_secuencial_param.sv
// Multi-cycle parametrised ALU with valid/ready handshakes, status flags and iterative MUL.
// Define ALU_DIV_EN to build the restoring divider behind opcode 1010.
module alu_secuencial_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, shift_big;
  logic [3:0]       sc_flags;
  logic             is_mul, is_div, accept;

  logic             md_start, md_op, md_done, md_v;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [3:0]       md_flags;

`ifdef ALU_DIV_EN
  logic             op_div_q, op_div_d;
  logic             b_zero_q, b_zero_d;
`endif

  alu_seq_muldiv #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .start(md_start),
    .op   (md_op),
    .a    (a),
    .b    (b),
    .done (md_done),
    .lo   (md_lo),
    .hi   (md_hi)
  );

  // Single-cycle datapath works straight off the inputs so the result registers at the accept edge
  always_comb begin
    add_full  = {1'b0, a} + {1'b0, b};
    sub_full  = {1'b0, a} - {1'b0, b};
    shift_big = (b >= W_LIM);
    sc_res    = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    case (sel)
      OP_ADD: begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_v   = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_res = sub_full[WIDTH-1:0];
        sc_c   = sub_full[WIDTH];
        sc_v   = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_SHL:  sc_res = shift_big ? '0 : (a << b);
      OP_SHR:  sc_res = shift_big ? '0 : (a >> b);
      OP_SRA:  sc_res = shift_big ? {WIDTH{a[MSB]}} : $unsigned($signed(a) >>> b);
      default: sc_res = '0;
    endcase
    sc_flags        = '0;
    sc_flags[FLG_Z] = (sc_res == '0);
    sc_flags[FLG_N] = sc_res[MSB];
    sc_flags[FLG_C] = sc_c;
    sc_flags[FLG_V] = sc_v;
  end

  always_comb begin
    is_mul = (sel == OP_MUL);
`ifdef ALU_DIV_EN
    is_div = is_div_op(sel);
    md_v   = op_div_q ? b_zero_q : (md_hi != '0);
`else
    is_div = 1'b0;
    md_v   = (md_hi != '0);
`endif
    md_flags        = '0;
    md_flags[FLG_Z] = (md_lo == '0);
    md_flags[FLG_N] = md_lo[MSB];
    md_flags[FLG_V] = md_v;
  end

  // Handshake FSM: IDLE accepts, BUSY waits for the iterative unit, DONE holds until out_ready
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    md_start    = 1'b0;
    md_op       = 1'b0;
    accept      = in_valid && in_ready_q;
`ifdef ALU_DIV_EN
    op_div_d    = op_div_q;
    b_zero_d    = b_zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          in_ready_d = 1'b0;
          if (is_mul || is_div) begin
            md_start = 1'b1;
            md_op    = is_div;
            state_d  = ST_BUSY;
            cnt_d    = CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
            op_div_d = is_div;
            b_zero_d = (b == '0);
`endif
          end else begin
            state_d     = ST_DONE;
            result_d    = sc_res;
            result_hi_d = '0;
            flags_d     = sc_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (md_done) begin
          state_d     = ST_DONE;
          result_d    = md_lo;
          result_hi_d = md_hi;
          flags_d     = md_flags;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_DIV_EN
      op_div_q    <= 1'b0;
      b_zero_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_DIV_EN
      op_div_q    <= op_div_d;
      b_zero_q    <= b_zero_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_secuencial_param.sv
// Directed self-checking bench for alu_secuencial_param at WIDTH = 8.
// DIV expectations follow ALU_DIV_EN: real divide when defined, illegal-sel otherwise.
module tb_alu_secuencial_param;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic [3:0] flags;

  int tests_run = 0;
  int tests_failed = 0;
  int lat;

  alu_secuencial_param #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result_hi(result_hi),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] isel);
    @(negedge clk);
    a = ia;
    b = ib;
    sel = isel;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counted so that a result registered at the accept edge reads as 1
  task automatic wait_result(output int cycles);
    int n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    cycles = out_valid ? n : -1;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sel = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, out_valid, result, result_hi, flags} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'h0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got rdy=%b vld=%b res=%h hi=%h fl=%b exp rdy=1 vld=0 res=00 hi=00 fl=0000",
               in_ready, out_valid, result, result_hi, flags);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    issue(8'hF0, 8'h20, OP_ADD);
    wait_result(lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("[TB] FAIL add_latency got %0d exp 1", lat);
    end
    tests_run++;
    if ({result, result_hi, flags} !== {8'h10, 8'h00, 4'b0100}) begin
      tests_failed++;
      $display("[TB] FAIL add_out got res=%h hi=%h fl=%b exp res=10 hi=00 fl=0100", result, result_hi, flags);
    end
    drain();
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL add_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_cycle;
    logic [3:0] t_sel [19] = '{OP_SUB, OP_SRA, OP_SHL, OP_AND, OP_OR, OP_XOR, OP_EQ, OP_EQ, OP_GT, OP_GT,
                               OP_SHR, OP_SRA, OP_ADD, OP_SUB, 4'hC, OP_SHR, OP_SHL, OP_SUB, 4'hF};
    logic [7:0] t_a [19] = '{8'h7F, 8'h90, 8'h01, 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h55, 8'h80, 8'h7F,
                             8'h80, 8'h90, 8'h7F, 8'h05, 8'h12, 8'hFF, 8'h81, 8'h00, 8'h33};
    logic [7:0] t_b [19] = '{8'hFF, 8'h09, 8'h08, 8'h3C, 8'h30, 8'hAA, 8'h55, 8'h54, 8'h7F, 8'h80,
                             8'h03, 8'h02, 8'h01, 8'h05, 8'h34, 8'h08, 8'h01, 8'h01, 8'h44};
    logic [7:0] t_res [19] = '{8'h80, 8'hFF, 8'h00, 8'h30, 8'h3F, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00,
                               8'h10, 8'hE4, 8'h80, 8'h00, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h00};
    logic [3:0] t_fl [19] = '{4'b1110, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001,
                              4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b1010, 4'b0001, 4'b0001, 4'b0001,
                              4'b0000, 4'b0110, 4'b0001};
    for (int i = 0; i < 19; i++) begin
      issue(t_a[i], t_b[i], t_sel[i]);
      wait_result(lat);
      tests_run++;
      if (lat !== 1) begin
        tests_failed++;
        $display("[TB] FAIL single_latency[%0d] got %0d exp 1", i, lat);
      end
      tests_run++;
      if ({result, result_hi, flags} !== {t_res[i], 8'h00, t_fl[i]}) begin
        tests_failed++;
        $display("[TB] FAIL single_out[%0d] sel=%h got res=%h hi=%h fl=%b exp res=%h hi=00 fl=%b",
                 i, t_sel[i], result, result_hi, flags, t_res[i], t_fl[i]);
      end
      drain();
    end
  endtask

  task automatic test_mul;
    issue(8'h0F, 8'h11, OP_MUL);
    wait_result(lat);
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("[TB] FAIL mul_small_latency got %0d exp 9", lat);
    end
    tests_run++;
    if ({result, result_hi, flags} !== {8'hFF, 8'h00, 4'b0010}) begin
      tests_failed++;
      $display("[TB] FAIL mul_small got res=%h hi=%h fl=%b exp res=FF hi=00 fl=0010", result, result_hi, flags);
    end
    drain();
    issue(8'hFF, 8'hFF, OP_MUL);
    wait_result(lat);
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("[TB] FAIL mul_big_latency got %0d exp 9", lat);
    end
    tests_run++;
    if ({result, result_hi, flags} !== {8'h01, 8'hFE, 4'b1000}) begin
      tests_failed++;
      $display("[TB] FAIL mul_big got res=%h hi=%h fl=%b exp res=01 hi=FE fl=1000", result, result_hi, flags);
    end
    drain();
  endtask

  task automatic test_div;
`ifdef ALU_DIV_EN
    issue(8'h64, 8'h07, OP_DIV);
    wait_result(lat);
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("[TB] FAIL div_latency got %0d exp 9", lat);
    end
    tests_run++;
    if ({result, result_hi, flags} !== {8'h0E, 8'h02, 4'b0000}) begin
      tests_failed++;
      $display("[TB] FAIL div_out got res=%h hi=%h fl=%b exp res=0E hi=02 fl=0000", result, result_hi, flags);
    end
    drain();
    issue(8'h64, 8'h00, OP_DIV);
    wait_result(lat);
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("[TB] FAIL div0_latency got %0d exp 9", lat);
    end
    tests_run++;
    if ({result, result_hi, flags} !== {8'hFF, 8'h64, 4'b1010}) begin
      tests_failed++;
      $display("[TB] FAIL div0_out got res=%h hi=%h fl=%b exp res=FF hi=64 fl=1010", result, result_hi, flags);
    end
    drain();
`else
    issue(8'h64, 8'h07, OP_DIV);
    wait_result(lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("[TB] FAIL nodiv_latency got %0d exp 1", lat);
    end
    tests_run++;
    if ({result, result_hi, flags} !== {8'h00, 8'h00, 4'b0001}) begin
      tests_failed++;
      $display("[TB] FAIL nodiv_out got res=%h hi=%h fl=%b exp res=00 hi=00 fl=0001", result, result_hi, flags);
    end
    drain();
`endif
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    issue(8'h03, 8'h04, OP_ADD);
    wait_result(lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("[TB] FAIL bp_latency got %0d exp 1", lat);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 8'h10;
        b = 8'h10;
        sel = OP_SUB;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({out_valid, in_ready, result, result_hi, flags} !== {1'b1, 1'b0, 8'h07, 8'h00, 4'b0000}) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold[%0d] got vld=%b rdy=%b res=%h hi=%h fl=%b exp vld=1 rdy=0 res=07 hi=00 fl=0000",
                 i, out_valid, in_ready, result, result_hi, flags);
      end
    end
    in_valid = 1'b0;
    drain();
    tests_run++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 8'h07}) begin
      tests_failed++;
      $display("[TB] FAIL bp_release got vld=%b rdy=%b res=%h exp vld=0 rdy=1 res=07", out_valid, in_ready, result);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL bp_no_ghost got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    issue(8'h0F, 8'h11, OP_MUL);
    wait_result(lat);
    drain();
    issue(8'h80, 8'h80, OP_ADD);
    wait_result(lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_latency got %0d exp 1", lat);
    end
    tests_run++;
    if ({result, result_hi, flags} !== {8'h00, 8'h00, 4'b1101}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_out got res=%h hi=%h fl=%b exp res=00 hi=00 fl=1101", result, result_hi, flags);
    end
    drain();
  endtask

  task automatic test_reset_mid;
    issue(8'h03, 8'h04, OP_ADD);
    wait_result(lat);
    drain();
    issue(8'hFF, 8'hFF, OP_MUL);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL mid_busy got vld=%b rdy=%b exp vld=0 rdy=0", out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, in_ready, result, result_hi, flags} !== {1'b0, 1'b1, 8'h00, 8'h00, 4'h0}) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset got vld=%b rdy=%b res=%h hi=%h fl=%b exp vld=0 rdy=1 res=00 hi=00 fl=0000",
               out_valid, in_ready, result, result_hi, flags);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(8'h01, 8'h01, OP_ADD);
    wait_result(lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_latency got %0d exp 1", lat);
    end
    tests_run++;
    if ({result, result_hi, flags} !== {8'h02, 8'h00, 4'b0000}) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_out got res=%h hi=%h fl=%b exp res=02 hi=00 fl=0000", result, result_hi, flags);
    end
    drain();
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 8'h02}) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_quiet got vld=%b rdy=%b res=%h exp vld=0 rdy=1 res=02", out_valid, in_ready, result);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_single_cycle();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
